tick_timer_arbiter: RTL and testbench
=====================================

# tick_timer_arbiter

Round-robin arbiter and sequencer that shares one baud-rate tick generator (25 MHz clock, 9600-baud tick, 17-bit count saturating at 96000) among several requesters. It grants the generator to one requester at a time and drives the generator's `start` for as long as that requester holds its request. It then captures the final tick count and returns it, tagged with the requester ID, through a valid/ready result port. It sits between the button/command front-ends and the single `ticks_generator` instance.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `TICK_W`, 17: width of the generator tick count.
- `MAX_TICKS`, 96000: generator saturation value; reaching it ends a run as a timeout.
- `ID_W`, `$clog2(N_REQ)`: requester index width (localparam).

- `clk`  in  1  system clock, 25 MHz.
- `rst_n`  in  1  reset: synchronous, active-low.
- `req`  in  N_REQ  level request per requester; held high for the interval being measured.
- `gnt`  out  N_REQ  one-hot grant, registered; high for the owner while RUN.
- `tg_start`  out  1  drives generator `start`, registered.
- `tg_ticks`  in  TICK_W  generator `ticks` output.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer accepts result.
- `res_ticks`  out  TICK_W  captured tick count.
- `res_id`  out  ID_W  index of the requester that produced the result.
- `res_timeout`  out  1  run ended by saturation, not by release.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, RUN, REPORT.
- **IDLE**
  - `tg_start`=0, `gnt`=0.
  - If any `req` bit is high, select the first set bit searching from `last+1` upward, wrapping modulo N_REQ.
  - Register `owner` and `last` <= selected index. Set `gnt[owner]`=1 and `tg_start`=1. Go to RUN.
- **RUN**
  - Evaluated every cycle, in priority order:
    - `req[owner]`=0: release. Latch `res_ticks` <= `tg_ticks`, `res_timeout` <= 0.
    - Else `tg_ticks` >= MAX_TICKS: timeout. Latch `res_ticks` <= `tg_ticks`, `res_timeout` <= 1.
  - If both conditions hold in the same cycle, release wins.
  - On either exit: `tg_start` <= 0, `gnt` <= 0, `res_id` <= `owner`, `res_valid` <= 1. Go to REPORT.
  - Requests from non-owners are ignored; they stay pending with no queueing beyond their level.
- **REPORT**
  - `res_*` outputs held stable while `res_valid`=1 and `res_ready`=0.
  - On `res_valid & res_ready`: `res_valid` <= 0, go to IDLE.
  - `tg_start` stays 0, which clears the generator (its `ticks` and counters drop to 0 the cycle after `start` falls).
- After a timeout the owner must drop `req` before it can win again. A still-high `req` is re-arbitrated normally and, if granted, starts a new run from 0.
- Captured count is the generator's registered value on the exit cycle; no arithmetic beyond the TICK_W compare.
- Reset (any cycle, including mid-RUN or REPORT):
  - State=IDLE, `last`=N_REQ-1 so requester 0 has first priority.
  - `gnt`=0, `tg_start`=0, `res_valid`=0, `res_ticks`=0, `res_id`=0, `res_timeout`=0, `busy`=0.
  - A result pending at reset is discarded.

## Timing
- Grant latency: `req` seen high in IDLE at edge k → `gnt` and `tg_start` high from edge k+1.
- Release latency: `req[owner]` low at edge k → `tg_start`/`gnt` low and `res_valid` high from edge k+1.
- Result handshake: transfer on a cycle with `res_valid & res_ready`. Next grant is possible at the earliest 1 cycle after return to IDLE.
- Minimum `tg_start` low gap between consecutive runs: 2 cycles (≥1 REPORT + 1 IDLE), so the generator is always cleared before restart.
- The generator's `ticks` lags its internal count by 1 cycle; results carry this lag. Tolerance vs ideal count is −1 tick.
- Throughput: one run per (hold time + 3 cycles) with `res_ready` tied high.

## Test plan
- **Single requester 0:** hold `req[0]` for 10×2605+5 cycles with the real generator, `res_ready`=1 → `res_ticks`=10 (9 accepted), `res_id`=0, `res_timeout`=0, `gnt`=0001 exactly during the hold.
- **All four requesting continuously from reset**, each releasing 100 cycles after grant → grant order 0,1,2,3,0; `res_ticks`=0 each; `tg_start` low ≥2 cycles between runs.
- **Timeout:** `MAX_TICKS` overridden to 5, `req[2]` held forever → `res_ticks`=5, `res_timeout`=1, `res_id`=2; `tg_start` falls 1 cycle after `tg_ticks` reaches 5.
- **Backpressure:** `res_ready`=0 for 50 cycles while `req[1]` is raised → `res_valid` and result stable, `gnt[1]` not asserted until 1 cycle after the handshake.
- **Reset mid-RUN:** `rst_n` low for 1 cycle during a run → next cycle all outputs 0, state IDLE; a subsequent request from requester 3 alongside 0 → 0 granted first.
- **One-cycle request:** `req[1]` high for 1 cycle only → granted, immediately released → `res_ticks`=0, `res_timeout`=0.

Source files
------------

// File: rtl/tick_timer_arbiter.sv
// tick_timer_arbiter: round-robin sharing of one tick generator, with the
// final count returned per requester over a valid/ready result port.
module tick_timer_arbiter #(
    parameter int N_REQ = 4,
    parameter int TICK_W = 17,
    parameter int MAX_TICKS = 96000,
    localparam int ID_W = $clog2(N_REQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_REQ-1:0]  req,
    output logic [N_REQ-1:0]  gnt,
    output logic              tg_start,
    input  logic [TICK_W-1:0] tg_ticks,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [TICK_W-1:0] res_ticks,
    output logic [ID_W-1:0]   res_id,
    output logic              res_timeout,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, RUN, REPORT} state_t;
    state_t              state_q;
    logic [ID_W-1:0]     owner_q, last_q, sel_d;
    logic                hit_d;
    logic [N_REQ-1:0]    gnt_q;
    logic                tg_start_q, res_valid_q, res_timeout_q;
    logic [TICK_W-1:0]   res_ticks_q;
    logic [ID_W-1:0]     res_id_q;
    int                  idx;
    // Descending scan so the nearest set bit after last_q is assigned last and wins.
    always_comb begin
        sel_d = last_q;
        hit_d = 1'b0;
        idx = 0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = (int'(last_q) + k) % N_REQ;
            if (req[ID_W'(idx)]) begin
                sel_d = ID_W'(idx);
                hit_d = 1'b1;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            last_q        <= ID_W'(N_REQ - 1);
            owner_q       <= '0;
            gnt_q         <= '0;
            tg_start_q    <= 1'b0;
            res_valid_q   <= 1'b0;
            res_ticks_q   <= '0;
            res_id_q      <= '0;
            res_timeout_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (hit_d) begin
                    owner_q    <= sel_d;
                    last_q     <= sel_d;
                    gnt_q      <= {{(N_REQ-1){1'b0}}, 1'b1} << sel_d;
                    tg_start_q <= 1'b1;
                    state_q    <= RUN;
                end
                // A still-held request at exit can only mean saturation, since release has priority.
                RUN: if (!req[owner_q] || tg_ticks >= TICK_W'(MAX_TICKS)) begin
                    res_ticks_q   <= tg_ticks;
                    res_timeout_q <= req[owner_q];
                    res_id_q      <= owner_q;
                    res_valid_q   <= 1'b1;
                    tg_start_q    <= 1'b0;
                    gnt_q         <= '0;
                    state_q       <= REPORT;
                end
                REPORT: if (res_ready) begin
                    res_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign gnt         = gnt_q;
    assign tg_start    = tg_start_q;
    assign res_valid   = res_valid_q;
    assign res_ticks   = res_ticks_q;
    assign res_id      = res_id_q;
    assign res_timeout = res_timeout_q;
    assign busy        = state_q != IDLE;
endmodule

// File: tb/tb_tick_timer_arbiter.sv
// tb_tick_timer_arbiter: directed checks of arbitration, release/timeout capture,
// backpressure and reset, with the generator tick count driven by the bench.
module tb_tick_timer_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = '0;
    logic [3:0]  gnt;
    logic        tg_start;
    logic [16:0] tg_ticks = '0;
    logic        res_valid;
    logic        res_ready = 1'b1;
    logic [16:0] res_ticks;
    logic [1:0]  res_id;
    logic        res_timeout;
    logic        busy;
    int          checks = 0;
    int          failures = 0;

    tick_timer_arbiter #(.N_REQ(4), .TICK_W(17), .MAX_TICKS(5)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt), .tg_start(tg_start),
        .tg_ticks(tg_ticks), .res_valid(res_valid), .res_ready(res_ready),
        .res_ticks(res_ticks), .res_id(res_id), .res_timeout(res_timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"}, 32'(gnt), 0);
        check({tag, "_start"}, 32'(tg_start), 0);
        check({tag, "_valid"}, 32'(res_valid), 0);
        check({tag, "_ticks"}, 32'(res_ticks), 0);
        check({tag, "_id"}, 32'(res_id), 0);
        check({tag, "_tmo"}, 32'(res_timeout), 0);
        check({tag, "_busy"}, 32'(busy), 0);
    endtask

    initial begin
        logic stable;
        int   exp_id [5] = '{0, 1, 2, 3, 0};
        tick();
        tick();
        check_all_zero("reset");
        rst_n = 1'b1;

        // single requester, released after tick count 3
        req = 4'b0001;
        tick();
        check("r0_gnt", 32'(gnt), 32'h1);
        check("r0_start", 32'(tg_start), 1);
        check("r0_busy", 32'(busy), 1);
        tg_ticks = 17'd3;
        tick();
        check("r0_hold_gnt", 32'(gnt), 32'h1);
        check("r0_hold_valid", 32'(res_valid), 0);
        req = 4'b0000;
        tick();
        check("r0_valid", 32'(res_valid), 1);
        check("r0_ticks", 32'(res_ticks), 3);
        check("r0_id", 32'(res_id), 0);
        check("r0_tmo", 32'(res_timeout), 0);
        check("r0_gnt_off", 32'(gnt), 0);
        check("r0_start_off", 32'(tg_start), 0);
        tg_ticks = '0;
        tick();
        check("r0_done_valid", 32'(res_valid), 0);
        check("r0_done_busy", 32'(busy), 0);

        // timeout on requester 2 held forever
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req = 4'b0100;
        tick();
        check("to_gnt", 32'(gnt), 32'h4);
        tg_ticks = 17'd4;
        tick();
        check("to_below_valid", 32'(res_valid), 0);
        check("to_below_start", 32'(tg_start), 1);
        tg_ticks = 17'd5;
        tick();
        check("to_valid", 32'(res_valid), 1);
        check("to_tmo", 32'(res_timeout), 1);
        check("to_ticks", 32'(res_ticks), 5);
        check("to_id", 32'(res_id), 2);
        check("to_start_off", 32'(tg_start), 0);
        tick();
        tg_ticks = '0;
        check("to_idle_start", 32'(tg_start), 0);
        tick();
        check("to_regrant", 32'(gnt), 32'h4);
        // release and saturation together: release wins
        tg_ticks = 17'd7;
        req = 4'b0000;
        tick();
        check("both_tmo", 32'(res_timeout), 0);
        check("both_ticks", 32'(res_ticks), 7);
        tick();
        tg_ticks = '0;

        // backpressure: last=2, so requester 1 wins
        res_ready = 1'b0;
        req = 4'b0010;
        tick();
        check("bp_gnt", 32'(gnt), 32'h2);
        tg_ticks = 17'd3;
        req = 4'b0000;
        tick();
        check("bp_valid", 32'(res_valid), 1);
        tg_ticks = '0;
        req = 4'b0010;
        stable = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (res_valid !== 1'b1 || res_ticks !== 17'd3 || res_id !== 2'd1 ||
                res_timeout !== 1'b0 || gnt !== 4'b0) stable = 1'b0;
        end
        check("bp_stable", 32'(stable), 1);
        res_ready = 1'b1;
        tick();
        check("bp_hs_valid", 32'(res_valid), 0);
        check("bp_hs_gnt", 32'(gnt), 0);
        tick();
        check("bp_regrant", 32'(gnt), 32'h2);

        // reset mid-run, then 3 and 0 together: 0 first
        rst_n = 1'b0;
        tick();
        check_all_zero("midrst");
        rst_n = 1'b1;
        req = 4'b1001;
        tick();
        check("midrst_gnt", 32'(gnt), 32'h1);

        // one-cycle request
        rst_n = 1'b0;
        req = 4'b0000;
        tick();
        rst_n = 1'b1;
        req = 4'b0010;
        tick();
        check("one_gnt", 32'(gnt), 32'h2);
        req = 4'b0000;
        tick();
        check("one_valid", 32'(res_valid), 1);
        check("one_ticks", 32'(res_ticks), 0);
        check("one_tmo", 32'(res_timeout), 0);
        check("one_id", 32'(res_id), 1);
        tick();

        // all four requesting: rotation 0,1,2,3,0
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rr_gnt", 32'(gnt), 32'h1 << exp_id[i]);
            req = 4'b1111 & ~(4'b0001 << exp_id[i]);
            tick();
            check("rr_id", 32'(res_id), 32'(exp_id[i]));
            check("rr_report_start", 32'(tg_start), 0);
            req = 4'b1111;
            tick();
            check("rr_idle_start", 32'(tg_start), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
